// File: rtl/reg_sel_pkg.sv
// Shared types and defaults for the register-select / register-list sequencer.
package reg_sel_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } seq_state_e;

  // Default LSB positions of the Ra/Rb/Rc fields and the register-list field in IR.
  localparam int unsigned DEF_RA_LSB   = 23;
  localparam int unsigned DEF_RB_LSB   = 19;
  localparam int unsigned DEF_RC_LSB   = 15;
  localparam int unsigned DEF_LIST_LSB = 0;

  // list_write: 1 drives Result_in (load-multiple), 0 drives Result_out (store-multiple).
  typedef enum logic {
    XFER_READ  = 1'b0,
    XFER_WRITE = 1'b1
  } xfer_dir_e;

  // list_desc: 1 walks the mask from the highest index down.
  typedef enum logic {
    ORDER_ASC  = 1'b0,
    ORDER_DESC = 1'b1
  } list_order_e;

endpackage

// File: rtl/reg_priority_pick.sv
// Priority picker: selects the lowest (ascending) or highest (descending) set bit of a mask.
module reg_priority_pick #(
  parameter  int unsigned NUM_REGS = 16,
  localparam int unsigned REG_W    = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0] mask_i,
  input  logic                desc_i,
  output logic [REG_W-1:0]    idx_o,
  output logic [NUM_REGS-1:0] onehot_o,
  output logic                any_o
);

  // Scan in reverse priority order so the last hit is the winning index.
  always_comb begin
    int unsigned j;
    idx_o    = '0;
    onehot_o = '0;
    any_o    = |mask_i;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      j = desc_i ? i : (NUM_REGS - 1 - i);
      if (mask_i[j]) idx_o = REG_W'(j);
    end
    if (any_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/reg_list_sequencer.sv
// Register-select unit: single-field Ra/Rb/Rc decode plus a sequenced register-list walker.
module reg_list_sequencer
  import reg_sel_pkg::*;
#(
  parameter  int unsigned NUM_REGS   = 16,
  parameter  int unsigned IR_W       = 32,
  parameter  int unsigned RA_LSB     = DEF_RA_LSB,
  parameter  int unsigned RB_LSB     = DEF_RB_LSB,
  parameter  int unsigned RC_LSB     = DEF_RC_LSB,
  parameter  int unsigned LIST_LSB   = DEF_LIST_LSB,
  parameter  int unsigned ZERO_GUARD = 1,
  localparam int unsigned REG_W      = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic [IR_W-1:0]     IR,
  input  logic                Gra,
  input  logic                Grb,
  input  logic                Grc,
  input  logic                Rin,
  input  logic                Rout,
  input  logic                BAout,
  input  logic                list_start,
  input  logic                list_write,
  input  logic                list_desc,
  input  logic                step,
  output logic [NUM_REGS-1:0] Result_in,
  output logic [NUM_REGS-1:0] Result_out,
  output logic                busy,
  output logic                done,
  output logic [REG_W-1:0]    cur_reg,
  output logic [REG_W:0]      xfer_count
);

  seq_state_e            state_q, state_d;
  logic [NUM_REGS-1:0]   mask_q, mask_d;
  xfer_dir_e             dir_q, dir_d;
  list_order_e           order_q, order_d;
  logic [REG_W:0]        xfer_q, xfer_d;

  logic [REG_W-1:0]      sel_field;
  logic                  sel_valid;
  logic [NUM_REGS-1:0]   single_dec;
  logic [NUM_REGS-1:0]   pick_mask;
  logic [REG_W-1:0]      pick_idx;
  logic [NUM_REGS-1:0]   pick_onehot;
  logic                  pick_any;

  // Only some IR bits are fields; fold the rest away.
  logic                  unused_ir;
  assign unused_ir = ^IR;

  // Single-mode field select and one-hot decode; R0 or an invalid select gives no enable.
  always_comb begin
    sel_field  = '0;
    sel_valid  = 1'b0;
    single_dec = '0;
    unique case ({Gra, Grb, Grc})
      3'b100:  begin sel_field = IR[RA_LSB +: REG_W]; sel_valid = 1'b1; end
      3'b010:  begin sel_field = IR[RB_LSB +: REG_W]; sel_valid = 1'b1; end
      3'b001:  begin sel_field = IR[RC_LSB +: REG_W]; sel_valid = 1'b1; end
      default: begin sel_field = '0;                  sel_valid = 1'b0; end
    endcase
    if (sel_valid && (sel_field != '0)) single_dec = NUM_REGS'(1) << sel_field;
  end

  // The picker serves both paths: in list mode it walks the latched mask, otherwise it
  // passes the (already one-hot) single-mode decode through unchanged.
  assign pick_mask = (state_q == S_ISSUE) ? mask_q : single_dec;

  reg_priority_pick #(
    .NUM_REGS (NUM_REGS)
  ) u_pick (
    .mask_i   (pick_mask),
    .desc_i   (order_q == ORDER_DESC),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot),
    .any_o    (pick_any)
  );

  // Sequencer state, latched list mask/mode and transfer counter.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      dir_q   <= XFER_READ;
      order_q <= ORDER_ASC;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dir_q   <= dir_d;
      order_q <= order_d;
      xfer_q  <= xfer_d;
    end
  end

  // Next-state logic: start latches the list, each step retires the current register.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dir_d   = dir_q;
    order_d = order_q;
    xfer_d  = xfer_q;
    unique case (state_q)
      S_IDLE: begin
        if (list_start) begin
          mask_d  = IR[LIST_LSB +: NUM_REGS];
          dir_d   = xfer_dir_e'(list_write);
          order_d = list_order_e'(list_desc);
          xfer_d  = '0;
          state_d = (IR[LIST_LSB +: NUM_REGS] != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (step && pick_any) begin
          mask_d = mask_q & ~pick_onehot;
          xfer_d = xfer_q + (REG_W+1)'(1);
          if (mask_d == '0) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output mux: combinational decode in IDLE, one list member in ISSUE, nothing in DONE.
  always_comb begin
    Result_in  = '0;
    Result_out = '0;
    unique case (state_q)
      S_IDLE: begin
        Result_in  = pick_onehot & {NUM_REGS{Rin}};
        Result_out = pick_onehot & {NUM_REGS{Rout | BAout}};
        if ((ZERO_GUARD != 0) && BAout && (sel_field == '0)) Result_out = '0;
      end
      S_ISSUE: begin
        if (dir_q == XFER_WRITE) Result_in  = pick_onehot;
        else                     Result_out = pick_onehot;
      end
      default: begin
        Result_in  = '0;
        Result_out = '0;
      end
    endcase
  end

  assign busy       = (state_q == S_ISSUE);
  assign done       = (state_q == S_DONE);
  assign cur_reg    = (state_q == S_ISSUE) ? pick_idx : '0;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Scoreboard bench for reg_list_sequencer (16-register and 32-register instances).
module tb_reg_list_sequencer;

  logic        clock = 1'b0;
  logic        clear_n;
  logic [31:0] IR;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        list_start, list_write, list_desc, step;
  logic [15:0] Result_in, Result_out;
  logic        busy, done;
  logic [3:0]  cur_reg;
  logic [4:0]  xfer_count;

  logic [31:0] ir32;
  logic        ls32, lw32, step32;
  logic [31:0] rin32, rout32;
  logic        busy32, done32;
  logic [4:0]  cur32;
  logic [5:0]  cnt32;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [15:0] rin;
    logic [15:0] rout;
    logic        busy;
    logic        done;
    logic [3:0]  cur;
    logic [4:0]  cnt;
    logic        stp;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  reg_list_sequencer #(.NUM_REGS(16)) dut (
    .clock(clock), .clear_n(clear_n), .IR(IR),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .list_start(list_start), .list_write(list_write), .list_desc(list_desc), .step(step),
    .Result_in(Result_in), .Result_out(Result_out), .busy(busy), .done(done),
    .cur_reg(cur_reg), .xfer_count(xfer_count)
  );

  reg_list_sequencer #(.NUM_REGS(32)) dut32 (
    .clock(clock), .clear_n(clear_n), .IR(ir32),
    .Gra(1'b0), .Grb(1'b0), .Grc(1'b0), .Rin(1'b0), .Rout(1'b0), .BAout(1'b0),
    .list_start(ls32), .list_write(lw32), .list_desc(1'b0), .step(step32),
    .Result_in(rin32), .Result_out(rout32), .busy(busy32), .done(done32),
    .cur_reg(cur32), .xfer_count(cnt32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_single();
    Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
  endtask

  // Build the expected cycle-by-cycle trace, then drive the start and compare each cycle.
  task automatic run_list(input string tag, input logic [15:0] mask, input logic wr,
                          input logic desc, input int period, input bit disturb);
    logic [15:0] rem;
    logic [4:0]  cnt;
    int          k;
    int          cur;
    exp_t        e;
    rem = mask; cnt = '0; k = 0;
    sb.delete();
    while (rem != 0) begin
      cur = -1;
      for (int i = 0; i < 16; i++)
        if (rem[i] && (desc || cur < 0)) cur = i;
      e.rin  = wr ? (16'h1 << cur) : 16'h0;
      e.rout = wr ? 16'h0 : (16'h1 << cur);
      e.busy = 1'b1; e.done = 1'b0; e.cur = 4'(cur); e.cnt = cnt;
      e.stp  = ((k % period) == (period - 1));
      sb.push_back(e);
      if (e.stp) begin rem[cur] = 1'b0; cnt++; end
      k++;
    end
    e.rin = '0; e.rout = '0; e.busy = 0; e.done = 1; e.cur = '0; e.cnt = cnt; e.stp = 0;
    sb.push_back(e);
    e.done = 0;
    sb.push_back(e);

    @(negedge clock);
    IR = {16'h0, mask}; list_start = 1; list_write = wr; list_desc = desc; step = 0;
    clear_single();
    while (sb.size() > 0) begin
      @(negedge clock);
      e = sb.pop_front();
      check({tag, ".rin"},  64'(Result_in),  64'(e.rin));
      check({tag, ".rout"}, 64'(Result_out), 64'(e.rout));
      check({tag, ".busy"}, 64'(busy),       64'(e.busy));
      check({tag, ".done"}, 64'(done),       64'(e.done));
      check({tag, ".cur"},  64'(cur_reg),    64'(e.cur));
      check({tag, ".cnt"},  64'(xfer_count), 64'(e.cnt));
      list_start = 0;
      step = e.stp;
      clear_single();
      if (disturb && e.busy) begin
        list_start = 1; Gra = 1; Rin = 1; IR = $urandom;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_n = 0; IR = '0; clear_single();
    list_start = 0; list_write = 0; list_desc = 0; step = 0;
    ir32 = '0; ls32 = 0; lw32 = 0; step32 = 0;

    @(negedge clock);
    check("rst.rin",  64'(Result_in),  64'h0);
    check("rst.rout", 64'(Result_out), 64'h0);
    check("rst.busy", 64'(busy),       64'h0);
    check("rst.done", 64'(done),       64'h0);
    check("rst.cur",  64'(cur_reg),    64'h0);
    check("rst.cnt",  64'(xfer_count), 64'h0);
    clear_n = 1;

    // Single-mode decode
    @(negedge clock);
    IR = 32'(5) << 23; Gra = 1; Rin = 1; #1;
    check("sgl.ra5.rin",  64'(Result_in),  64'h0020);
    check("sgl.ra5.rout", 64'(Result_out), 64'h0000);
    Grb = 1; #1;
    check("sgl.multi.rin",  64'(Result_in),  64'h0);
    check("sgl.multi.rout", 64'(Result_out), 64'h0);
    Grb = 0; Rin = 0; BAout = 1; IR = '0; #1;
    check("sgl.r0ba.rout", 64'(Result_out), 64'h0);
    IR = 32'(7) << 23; #1;
    check("sgl.ra7ba.rout", 64'(Result_out), 64'h0080);
    clear_single(); Grb = 1; Rout = 1; IR = 32'(9) << 19; #1;
    check("sgl.rb9.rout", 64'(Result_out), 64'h0200);
    check("sgl.rb9.rin",  64'(Result_in),  64'h0);
    clear_single(); Grc = 1; Rin = 1; IR = 32'(3) << 15; #1;
    check("sgl.rc3.rin", 64'(Result_in), 64'h0008);
    clear_single(); Rin = 1; IR = 32'(3) << 15; #1;
    check("sgl.nosel.rin", 64'(Result_in), 64'h0);
    clear_single();

    run_list("asc_wr",  16'h8091, 1'b1, 1'b0, 1, 1'b0);
    run_list("desc_rd", 16'h0006, 1'b0, 1'b1, 3, 1'b0);
    run_list("empty",   16'h0000, 1'b1, 1'b0, 1, 1'b0);

    // Reset during the second of four transfers
    @(negedge clock);
    IR = 32'h0000_00F0; list_start = 1; list_write = 1; list_desc = 0; step = 1;
    @(negedge clock);
    list_start = 0;
    check("rmid.first.rin", 64'(Result_in), 64'h0010);
    @(negedge clock);
    check("rmid.second.rin", 64'(Result_in), 64'h0020);
    #2 clear_n = 0; #1;
    check("rmid.async.rin",  64'(Result_in),  64'h0);
    check("rmid.async.busy", 64'(busy),       64'h0);
    check("rmid.async.done", 64'(done),       64'h0);
    check("rmid.async.cnt",  64'(xfer_count), 64'h0);
    @(negedge clock);
    check("rmid.held.done", 64'(done), 64'h0);
    clear_n = 1; step = 0;
    @(negedge clock);
    check("rmid.rel.done", 64'(done), 64'h0);
    check("rmid.rel.busy", 64'(busy), 64'h0);
    run_list("rerun", 16'h00F0, 1'b1, 1'b0, 1, 1'b0);

    // Inputs that must be ignored during ISSUE
    run_list("disturb", 16'h0A50, 1'b0, 1'b1, 2, 1'b1);

    // 32-register instance, top list bit
    @(negedge clock);
    ir32 = 32'h8000_0000; ls32 = 1; lw32 = 1; step32 = 1;
    @(negedge clock);
    ls32 = 0;
    check("r32.rin",  64'(rin32),  64'h8000_0000);
    check("r32.rout", 64'(rout32), 64'h0);
    check("r32.cur",  64'(cur32),  64'd31);
    check("r32.busy", 64'(busy32), 64'h1);
    @(negedge clock);
    check("r32.done", 64'(done32), 64'h1);
    check("r32.cnt",  64'(cnt32),  64'd1);
    check("r32.off",  64'(rin32),  64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_list_sequencer.md
# reg_list_sequencer

Parametrised register-select unit for the datapath control path. It performs the single-field Ra/Rb/Rc select-and-decode into one-hot register-file enables, generalised to NUM_REGS registers. It adds a sequenced register-list mode (load/store-multiple): it walks a register bitmask from the IR one register per handshake, ascending or descending. It sits between the control unit and the register-file in/out enables.

## Interface
- NUM_REGS, 16: registers in file; power of two, 2..32; REG_W = $clog2(NUM_REGS)
- IR_W, 32: instruction register width
- RA_LSB, 23 / RB_LSB, 19 / RC_LSB, 15: LSB of each REG_W-bit field in IR
- LIST_LSB, 0: LSB of NUM_REGS-bit register-list field in IR
- ZERO_GUARD, 1: 1 = BAout forces zero output when R0 is selected (single mode only)

Ports:
- clock  in  1  rising-edge clock; the block's only clock
- clear_n  in  1  asynchronous, active-low reset
- IR  in  IR_W  instruction register
- Gra, Grb, Grc  in  1  single-mode field select (exactly one valid)
- Rin, Rout, BAout  in  1  single-mode enables
- list_start  in  1  start list sequence (sampled in IDLE only)
- list_write  in  1  1 = drive Result_in (load-multiple), 0 = drive Result_out (store-multiple); latched at start
- list_desc  in  1  1 = highest index first; latched at start
- step  in  1  current transfer complete; advance
- Result_in, Result_out  out  NUM_REGS  one-hot register enables
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- cur_reg  out  REG_W  index currently driven (valid while busy)
- xfer_count  out  REG_W+1  transfers completed in current/last sequence

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: outputs are combinational single-field decode.
  - Exactly one of Gra/Grb/Grc selects field; zero or multiple -> index 0 with enable off.
  - Field value 0 -> no enable.
  - Result_in = decode & Rin; Result_out = decode & (Rout|BAout).
  - With ZERO_GUARD and BAout, a selection of R0 yields zero.
- IDLE + list_start: latch mask = IR[LIST_LSB +: NUM_REGS], list_write, list_desc; clear xfer_count.
  - mask != 0 -> ISSUE; mask == 0 -> DONE (zero transfers).
- ISSUE: cur_reg = lowest set mask bit (ascending) or highest (descending).
  - Drive bit cur_reg on Result_in (write) or Result_out (read); the other vector is 0.
  - Single-mode inputs ignored. R0 is a legal list member; no zero guard.
  - step=1 at edge: clear mask[cur_reg], xfer_count+1; remaining mask 0 -> DONE, else stay.
  - step=0: hold.
- DONE: done=1, enables 0, busy=0; -> IDLE next cycle. xfer_count holds until next list_start.
- list_start while not IDLE ignored. IR changes after start have no effect on latched mask.

## Timing
- Reset (async assert, any state): state IDLE, mask 0, cur_reg 0, xfer_count 0, done 0, busy 0; enables = single-mode decode of current inputs (0 with Rin/Rout/BAout low).
- list_start edge at t -> busy and first enable at t+1.
- Each enable held >=1 cycle; next register at cycle after step edge.
- N-bit mask with step held high: enables t+1..t+N, done at t+N+1, IDLE at t+N+2.
- Empty mask: done at t+1, no enable ever asserted.
- Reset mid-ISSUE: enables drop immediately (asynchronous), no done pulse.

## Structure
- Package reg_sel_pkg:
  - state enum (IDLE, ISSUE, DONE)
  - default field LSB constants
  - mode encodings for list_write and list_desc
- Sub-module reg_priority_pick: NUM_REGS mask + desc -> index, one-hot, any. Combinational; shared with the single-mode decoder path.
- Top: FSM, mask/counter registers, output mux.

## Test plan
- Single mode: IR[26:23]=5, Gra=1, Rin=1 -> Result_in=0x0020, Result_out=0. Gra=Grb=1 -> both 0. Ra=0, BAout=1 -> Result_out=0.
- List ascending write: mask 0x8091, step tied 1 -> Result_in 0x0001, 0x0010, 0x0080, 0x8000 on consecutive cycles; done next cycle; xfer_count=4.
- List descending read with step stalls: mask 0x0006, step high every 3rd cycle -> Result_out 0x0004 held until step, then 0x0002; done after second step.
- Empty mask: list_start with mask 0 -> done at t+1, busy never 1, xfer_count=0.
- Reset mid-sequence: clear_n low during second of 4 transfers -> enables 0 asynchronously, no done. New start after release -> full 4-transfer sequence.
- Ignored inputs: list_start and Gra/Rin pulsed during ISSUE, IR changed -> sequence unaffected. NUM_REGS=32 instance: mask bit 31 -> Result_in[31].
